// File: rtl/instr_buffer_pkg.sv
// instr_buffer_pkg: shared widths and queue entry layout for the fetch-to-decode buffer
package instr_buffer_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam int TGT_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc;
    logic taken;
    logic [TGT_W-1:0] target;
  } ibuf_entry_t;
endpackage

// File: rtl/instr_buffer_if.sv
// instr_buffer_if: IFU, decoder and backend-control signals around the instruction buffer
interface instr_buffer_if;
  import instr_buffer_pkg::*;
  logic flush_valid;
  logic end_of_program;
  logic ifu2ibuf_valid;
  logic ifu2ibuf_instr1_valid;
  logic [INSTR_W-1:0] ifu2ibuf_instr0;
  logic [INSTR_W-1:0] ifu2ibuf_instr1;
  logic [PC_W-1:0] ifu2ibuf_pc;
  logic ifu2ibuf_predicttaken0;
  logic ifu2ibuf_predicttaken1;
  logic [TGT_W-1:0] ifu2ibuf_predicttarget;
  logic ibuf2ifu_ready;
  logic ibuffer_instr_valid;
  logic [INSTR_W-1:0] ibuffer_inst_out;
  logic [PC_W-1:0] ibuffer_pc_out;
  logic ibuffer_predicttaken_out;
  logic [TGT_W-1:0] ibuffer_predicttarget_out;
  logic ibuffer_instr_ready;
  modport master (
    output flush_valid, end_of_program, ifu2ibuf_valid, ifu2ibuf_instr1_valid, ifu2ibuf_instr0,
           ifu2ibuf_instr1, ifu2ibuf_pc, ifu2ibuf_predicttaken0, ifu2ibuf_predicttaken1,
           ifu2ibuf_predicttarget, ibuffer_instr_ready,
    input  ibuf2ifu_ready, ibuffer_instr_valid, ibuffer_inst_out, ibuffer_pc_out,
           ibuffer_predicttaken_out, ibuffer_predicttarget_out
  );
  modport slave (
    input  flush_valid, end_of_program, ifu2ibuf_valid, ifu2ibuf_instr1_valid, ifu2ibuf_instr0,
           ifu2ibuf_instr1, ifu2ibuf_pc, ifu2ibuf_predicttaken0, ifu2ibuf_predicttaken1,
           ifu2ibuf_predicttarget, ibuffer_instr_ready,
    output ibuf2ifu_ready, ibuffer_instr_valid, ibuffer_inst_out, ibuffer_pc_out,
           ibuffer_predicttaken_out, ibuffer_predicttarget_out
  );
endinterface

// File: rtl/instr_buffer_ptr_ctrl.sv
// instr_buffer_ptr_ctrl: read/write pointers and occupancy with 0/1/2-entry enqueue accounting
module instr_buffer_ptr_ctrl #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PTR_W = AW + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic enq,
  input  logic enq2,
  input  logic deq,
  output logic [AW-1:0] rd_idx,
  output logic [AW-1:0] wr_idx,
  output logic [PTR_W-1:0] count,
  output logic empty
);
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
  logic [1:0] n_enq;
  always_comb begin
    n_enq = {1'b0, enq} + {1'b0, enq & enq2};
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(deq);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(n_enq);
    count_d = flush ? '0 : count_q + PTR_W'(n_enq) - PTR_W'(deq);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign count = count_q;
  assign empty = count_q == '0;
endmodule

// File: rtl/instr_buffer.sv
// instr_buffer: 2-in/1-out FWFT instruction queue between IFU and decode, cleared by flush
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic clock,
  input logic reset,
  instr_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  ibuf_entry_t mem_q [DEPTH];
  ibuf_entry_t mem_d [DEPTH];
  ibuf_entry_t e0, e1, head;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [PTR_W-1:0] count;
  logic empty, ready, enq, enq2, deq;
  instr_buffer_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clock(clock), .reset(reset), .flush(bus.flush_valid), .enq(enq), .enq2(enq2), .deq(deq),
    .rd_idx(rd_idx), .wr_idx(wr_idx), .count(count), .empty(empty)
  );
  // Always reserve room for a full pair so a group is never split across cycles
  always_comb begin
    ready = (count <= PTR_W'(DEPTH - 2)) & ~bus.end_of_program & ~bus.flush_valid;
    enq = bus.ifu2ibuf_valid & ready;
    enq2 = bus.ifu2ibuf_instr1_valid & ~bus.ifu2ibuf_predicttaken0;
    deq = ~empty & bus.ibuffer_instr_ready;
    e0 = '{instr: bus.ifu2ibuf_instr0, pc: bus.ifu2ibuf_pc, taken: bus.ifu2ibuf_predicttaken0,
           target: bus.ifu2ibuf_predicttaken0 ? bus.ifu2ibuf_predicttarget : '0};
    e1 = '{instr: bus.ifu2ibuf_instr1, pc: bus.ifu2ibuf_pc + PC_W'(4), taken: bus.ifu2ibuf_predicttaken1,
           target: bus.ifu2ibuf_predicttaken1 ? bus.ifu2ibuf_predicttarget : '0};
    mem_d = mem_q;
    if (enq) mem_d[wr_idx] = e0;
    if (enq & enq2) mem_d[wr_idx + AW'(1)] = e1;
    head = empty ? '0 : mem_q[rd_idx];
  end
  always_ff @(posedge clock) mem_q <= mem_d;
  assign bus.ibuf2ifu_ready = ready;
  assign bus.ibuffer_instr_valid = ~empty;
  assign bus.ibuffer_inst_out = head.instr;
  assign bus.ibuffer_pc_out = head.pc;
  assign bus.ibuffer_predicttaken_out = head.taken;
  assign bus.ibuffer_predicttarget_out = head.target;
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: scoreboard bench for the instruction buffer
module tb_instr_buffer;
  import instr_buffer_pkg::*;
  localparam int DEPTH = 8;
  logic clock = 0;
  logic reset = 1;
  int n_checks = 0;
  int n_errors = 0;
  int id = 0;
  logic [31:0] pc_gen = 32'h8000_2000;
  ibuf_entry_t sb[$];
  instr_buffer_if bus();
  instr_buffer #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic group(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc,
                       input logic v1, input logic t0, input logic t1, input logic [31:0] tgt);
    bus.ifu2ibuf_valid = 1;
    bus.ifu2ibuf_instr0 = i0;
    bus.ifu2ibuf_instr1 = i1;
    bus.ifu2ibuf_pc = pc;
    bus.ifu2ibuf_instr1_valid = v1;
    bus.ifu2ibuf_predicttaken0 = t0;
    bus.ifu2ibuf_predicttaken1 = t1;
    bus.ifu2ibuf_predicttarget = tgt;
  endtask

  task automatic next_group(input logic v1, input logic t0, input logic t1);
    id++;
    group({16'hA000, id[15:0]}, {16'hB000, id[15:0]}, pc_gen, v1, t0, t1, {16'hC000, id[15:0]});
    pc_gen = pc_gen + 32'd8;
  endtask

  // Check the current outputs against the model, then advance model and DUT by one clock
  task automatic cycle();
    ibuf_entry_t e;
    logic vld, rdy;
    #1;
    vld = sb.size() != 0;
    rdy = (DEPTH - sb.size() >= 2) && !bus.end_of_program && !bus.flush_valid;
    e = vld ? sb[0] : '0;
    check("valid", 64'(bus.ibuffer_instr_valid), 64'(vld));
    check("ready", 64'(bus.ibuf2ifu_ready), 64'(rdy));
    check("count", 64'(dut.count), 64'(sb.size()));
    check("instr", 64'(bus.ibuffer_inst_out), 64'(e.instr));
    check("pc", 64'(bus.ibuffer_pc_out), 64'(e.pc));
    check("taken", 64'(bus.ibuffer_predicttaken_out), 64'(e.taken));
    check("target", 64'(bus.ibuffer_predicttarget_out), 64'(e.target));
    if (reset || bus.flush_valid) sb.delete();
    else begin
      if (vld && bus.ibuffer_instr_ready) void'(sb.pop_front());
      if (bus.ifu2ibuf_valid && rdy) begin
        sb.push_back('{bus.ifu2ibuf_instr0, bus.ifu2ibuf_pc, bus.ifu2ibuf_predicttaken0,
                       bus.ifu2ibuf_predicttaken0 ? bus.ifu2ibuf_predicttarget : 32'h0});
        if (bus.ifu2ibuf_instr1_valid && !bus.ifu2ibuf_predicttaken0)
          sb.push_back('{bus.ifu2ibuf_instr1, bus.ifu2ibuf_pc + 32'd4, bus.ifu2ibuf_predicttaken1,
                         bus.ifu2ibuf_predicttaken1 ? bus.ifu2ibuf_predicttarget : 32'h0});
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain();
    bus.ifu2ibuf_valid = 0;
    bus.ibuffer_instr_ready = 1;
    repeat (DEPTH + 2) cycle();
  endtask

  initial begin
    bus.flush_valid = 0;
    bus.end_of_program = 0;
    bus.ibuffer_instr_ready = 0;
    group(0, 0, 0, 0, 0, 0, 0);
    bus.ifu2ibuf_valid = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    // basic pair, no prediction
    bus.ibuffer_instr_ready = 1;
    group(32'h0000_0013, 32'h0010_0093, 32'h8000_0000, 1, 0, 0, 32'h0);
    cycle();
    bus.ifu2ibuf_valid = 0;
    repeat (3) cycle();
    // taken slot0 drops slot1
    bus.ibuffer_instr_ready = 0;
    group(32'h0000_006F, 32'h0010_0093, 32'h8000_0010, 1, 1, 0, 32'h8000_0100);
    cycle();
    bus.ifu2ibuf_valid = 0;
    cycle();
    drain();
    // fill to full, then hit the count=7 single-group rejection
    bus.ibuffer_instr_ready = 0;
    repeat (5) begin next_group(1, 0, 0); cycle(); end
    drain();
    bus.ibuffer_instr_ready = 0;
    next_group(0, 0, 0); cycle();
    repeat (3) begin next_group(1, 0, 1); cycle(); end
    next_group(0, 0, 0); cycle();
    drain();
    // enqueue 2 + dequeue 1 at count 4
    bus.ibuffer_instr_ready = 0;
    repeat (2) begin next_group(1, 0, 0); cycle(); end
    bus.ibuffer_instr_ready = 1;
    next_group(1, 0, 0); cycle();
    bus.ifu2ibuf_valid = 0;
    cycle();
    // long random run to wrap pointers several times
    repeat (60) begin
      next_group($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      bus.ifu2ibuf_valid = $urandom_range(0, 3) != 0;
      bus.ibuffer_instr_ready = $urandom_range(0, 2) != 0;
      cycle();
    end
    drain();
    // flush with count 6 and concurrent enq/deq
    bus.ibuffer_instr_ready = 0;
    repeat (3) begin next_group(1, 0, 0); cycle(); end
    bus.flush_valid = 1;
    bus.ibuffer_instr_ready = 1;
    next_group(1, 0, 0); cycle();
    bus.flush_valid = 0;
    next_group(1, 1, 0); cycle();
    bus.ifu2ibuf_valid = 0;
    repeat (2) cycle();
    // end_of_program gates ready but queue drains
    bus.ibuffer_instr_ready = 0;
    next_group(1, 0, 0); cycle();
    next_group(0, 0, 0); cycle();
    bus.end_of_program = 1;
    bus.ibuffer_instr_ready = 1;
    next_group(1, 0, 0);
    repeat (5) cycle();
    bus.end_of_program = 0;
    // reset mid-drain
    bus.ibuffer_instr_ready = 0;
    next_group(1, 0, 0); cycle();
    next_group(0, 0, 0); cycle();
    bus.ifu2ibuf_valid = 0;
    bus.ibuffer_instr_ready = 1;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
